// File: rtl/dp_mem_pkg.sv
// Shared types and default geometry for the dual-port memory and its burst initiator.
package dp_mem_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF  = 16;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_e;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;
endpackage

// File: rtl/dp_mem_burst_cnt.sv
// Burst address register (wraps modulo DEPTH) and beat down-counter.
module dp_mem_burst_cnt #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [LEN_W-1:0]  ld_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  // DEPTH is a power of two, so masking keeps the address modulo DEPTH
  // and holds the bits above log2(DEPTH) at zero.
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  beats;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      beats  <= '0;
    end else if (load) begin
      addr_q <= ld_addr & MASK;
      beats  <= ld_len;
    end else if (step) begin
      addr_q <= (addr_q + 1'b1) & MASK;
      if (beats != '0) beats <= beats - 1'b1;
    end
  end

  assign addr = addr_q;
  assign last = (beats == '0);
endmodule

// File: rtl/dp_mem_ctrl.sv
// Burst initiator: turns read/write burst commands into one memory access per cycle.
module dp_mem_ctrl
  import dp_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdat_valid,
  output logic              wdat_ready,
  input  logic [DATA_W-1:0] wdat,
  output logic              rdat_valid,
  output logic [DATA_W-1:0] rdat,
  output logic              rdat_last,
  output logic              busy,
  output logic              mem_enb,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data
);
  state_e            state, state_nxt;
  logic              load, last;
  logic [ADDR_W-1:0] addr;

  dp_mem_burst_cnt #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (mem_enb),
    .ld_addr (cmd_addr),
    .ld_len  (cmd_len),
    .addr    (addr),
    .last    (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    mem_enb   = 1'b0;
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        load      = 1'b1;
        state_nxt = (op_e'(cmd_op) == OP_WRITE) ? WRITE : READ;
      end
      WRITE: if (wdat_valid) begin
        mem_enb = 1'b1;
        mem_wr  = 1'b1;
        if (last) state_nxt = IDLE;
      end
      READ: begin
        mem_enb = 1'b1;
        mem_rd  = 1'b1;
        if (last) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data buses are held at zero whenever their strobe is low.
  assign mem_w_addr = mem_wr ? addr : '0;
  assign mem_r_addr = mem_rd ? addr : '0;
  assign mem_w_data = mem_wr ? wdat : '0;
  assign rdat       = mem_r_data;

  // Status flags decode the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      wdat_ready <= 1'b0;
      rdat_valid <= 1'b0;
      rdat_last  <= 1'b0;
    end else begin
      cmd_ready  <= (state_nxt == IDLE);
      busy       <= (state_nxt != IDLE);
      wdat_ready <= (state_nxt == WRITE);
      rdat_valid <= mem_rd;
      rdat_last  <= mem_rd & last;
    end
  end
endmodule

// File: tb/tb_dp_mem_ctrl.sv
// Randomized bench for dp_mem_ctrl against a registered-read memory and an array reference.
module tb_dp_mem_ctrl;
  localparam int DW = 8, AW = 5, DEPTH = 16, LW = 4;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic wdat_valid, wdat_ready;
  logic [DW-1:0] wdat, rdat, mem_w_data, mem_r_data;
  logic rdat_valid, rdat_last, busy, mem_enb, mem_wr, mem_rd;
  logic [AW-1:0] mem_w_addr, mem_r_addr;

  always #5 clk = ~clk;

  dp_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
    .rdat_valid(rdat_valid), .rdat(rdat), .rdat_last(rdat_last), .busy(busy),
    .mem_enb(mem_enb), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_w_addr(mem_w_addr), .mem_r_addr(mem_r_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  // Memory with one-cycle registered read
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] mem_rq;
  always @(posedge clk) begin
    if (mem_enb && mem_wr) mem[mem_w_addr[3:0]] <= mem_w_data;
    if (mem_enb && mem_rd) mem_rq <= mem[mem_r_addr[3:0]];
  end
  assign mem_r_data = mem_rq;

  logic [DW-1:0] ref_mem [0:DEPTH-1];
  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    chk("wr_rd_excl", 32'(mem_wr & mem_rd), 0);
  end

  // gap_mode < 0: random 0..2 idle cycles before each beat; else fixed gaps between beats.
  // dbase < 0: random data; else beat i carries dbase+i.
  task automatic do_write(input logic [AW-1:0] a, input int len, input int gap_mode, input int dbase);
    logic [DW-1:0] d;
    int ng, idx;
    @(negedge clk); #1;
    chk("wr_cmd_ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = a; cmd_len = LW'(len);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_len = LW'($urandom); wdat_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      ng = (gap_mode < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gap_mode);
      for (int g = 0; g < ng; g++) begin
        @(negedge clk); wdat_valid = 1'b0; wdat = DW'($urandom); #1;
        chk("wr_gap_enb", 32'(mem_enb), 0);
        chk("wr_gap_wready", 32'(wdat_ready), 1);
      end
      d = (dbase < 0) ? DW'($urandom) : DW'(dbase + i);
      idx = (int'(a) + i) % DEPTH;
      @(negedge clk); wdat_valid = 1'b1; wdat = d; #1;
      chk("wr_enb", 32'(mem_enb), 1);
      chk("wr_wr", 32'(mem_wr), 1);
      chk("wr_rd", 32'(mem_rd), 0);
      chk("wr_addr", 32'(mem_w_addr), 32'(idx));
      chk("wr_data", 32'(mem_w_data), 32'(d));
      chk("wr_wready", 32'(wdat_ready), 1);
      chk("wr_busy", 32'(busy), 1);
      ref_mem[idx] = d;
    end
    // back in IDLE: stray write beats must be ignored
    @(negedge clk); wdat_valid = 1'b1; #1;
    chk("wr_done_cready", 32'(cmd_ready), 1);
    chk("wr_done_busy", 32'(busy), 0);
    chk("wr_done_wready", 32'(wdat_ready), 0);
    chk("wr_done_enb", 32'(mem_enb), 0);
    wdat_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int len);
    @(negedge clk); #1;
    chk("rd_cmd_ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = a; cmd_len = LW'(len);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_addr = AW'($urandom); wdat_valid = 1'($urandom);
    for (int k = 0; k <= len; k++) begin
      @(negedge clk); #1;
      chk("rd_enb", 32'(mem_enb), 1);
      chk("rd_rd", 32'(mem_rd), 1);
      chk("rd_wr", 32'(mem_wr), 0);
      chk("rd_addr", 32'(mem_r_addr), 32'((int'(a) + k) % DEPTH));
      chk("rd_cready", 32'(cmd_ready), 0);
      if (k == 0) chk("rd_vld0", 32'(rdat_valid), 0);
      else begin
        chk("rd_vld", 32'(rdat_valid), 1);
        chk("rd_data", 32'(rdat), 32'(ref_mem[(int'(a) + k - 1) % DEPTH]));
        chk("rd_last0", 32'(rdat_last), 0);
      end
    end
    @(negedge clk); #1;
    chk("drain_enb", 32'(mem_enb), 0);
    chk("drain_vld", 32'(rdat_valid), 1);
    chk("drain_data", 32'(rdat), 32'(ref_mem[(int'(a) + len) % DEPTH]));
    chk("drain_last", 32'(rdat_last), 1);
    chk("drain_busy", 32'(busy), 1);
    chk("drain_cready", 32'(cmd_ready), 0);
    @(negedge clk); #1;
    chk("rd_done_cready", 32'(cmd_ready), 1);
    chk("rd_done_vld", 32'(rdat_valid), 0);
    chk("rd_done_last", 32'(rdat_last), 0);
    chk("rd_done_busy", 32'(busy), 0);
    wdat_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdat_valid = 1'b0; wdat = '0;
    #1;
    chk("rst_cready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wready", 32'(wdat_ready), 0);
    chk("rst_vld", 32'(rdat_valid), 0);
    chk("rst_last", 32'(rdat_last), 0);
    chk("rst_mem_ctl", {29'b0, mem_enb, mem_wr, mem_rd}, 0);
    chk("rst_mem_bus", {14'b0, mem_w_addr, mem_r_addr, mem_w_data}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_write(5'd0, 15, 0, -1);           // preload every word
    do_write(5'd3, 0, 0, 'hA5);
    do_write(5'd14, 3, 0, 'h10);
    do_read(5'd14, 3);
    do_write(5'd6, 2, 2, -1);
    do_read(5'd6, 2);

    // reset during the 2nd beat of a 4-beat read
    @(negedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 5'd2; cmd_len = 4'd3;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk); #1 chk("rr_beat0_rd", 32'(mem_rd), 1);
    @(negedge clk); #1 rst = 1'b1; #1;
    chk("rr_enb", 32'(mem_enb), 0);
    chk("rr_rd", 32'(mem_rd), 0);
    chk("rr_raddr", 32'(mem_r_addr), 0);
    chk("rr_vld", 32'(rdat_valid), 0);
    chk("rr_last", 32'(rdat_last), 0);
    chk("rr_cready", 32'(cmd_ready), 1);
    chk("rr_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("rr_post_vld", 32'(rdat_valid), 0);
      chk("rr_post_cready", 32'(cmd_ready), 1);
      chk("rr_post_enb", 32'(mem_enb), 0);
    end

    do_write(5'd5, 1, 0, -1);
    do_read(5'd5, 1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(AW'($urandom_range(0, 31)), int'($urandom_range(0, 15)), -1, -1);
      else
        do_read(AW'($urandom_range(0, 31)), int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dp_mem_ctrl.md
# dp_mem_ctrl

Burst initiator that drives the dual-port memory's `enb`/`wr`/`rd`/address/data port on behalf of a client. It accepts read or write burst commands over a valid/ready handshake and streams write data in. It issues one memory access per cycle with wrapping addresses and returns read data as a valid-qualified stream. It sits between client logic and the memory, as the requesting end of the memory's command interface.

## Interface
- `DATA_W`, 8, data width; matches memory word.
- `ADDR_W`, 5, memory address port width.
- `DEPTH`, 16, number of memory words; power of two, ≤ 2**ADDR_W.
- `LEN_W`, 4, burst length field width; burst length = `cmd_len`+1 (1..16).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller accepts a command; high only in IDLE.
- `cmd_op`  in  1  0 = read burst, 1 = write burst.
- `cmd_addr`  in  ADDR_W  start address; taken modulo DEPTH.
- `cmd_len`  in  LEN_W  beats minus one.
- `wdat_valid`  in  1  write beat present.
- `wdat_ready`  out  1  write beat accepted; high only in WRITE.
- `wdat`  in  DATA_W  write beat data.
- `rdat_valid`  out  1  read beat valid; no backpressure.
- `rdat`  out  DATA_W  read beat data.
- `rdat_last`  out  1  final beat of read burst.
- `busy`  out  1  state ≠ IDLE.
- `mem_enb`, `mem_wr`, `mem_rd`  out  1 each  memory controls.
- `mem_w_addr`, `mem_r_addr`  out  ADDR_W  memory addresses; bits above log2(DEPTH) driven 0.
- `mem_w_data`  out  DATA_W  memory write data.
- `mem_r_data`  in  DATA_W  memory read data; registered by memory, valid the cycle after `mem_rd`.

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch `addr`=`cmd_addr` mod DEPTH and `beats`=`cmd_len`.
  - Go to WRITE (op=1) or READ (op=0).
- WRITE:
  - `wdat_ready`=1.
  - Each cycle with `wdat_valid`: `mem_enb`=1, `mem_wr`=1, `mem_rd`=0, `mem_w_addr`=addr, `mem_w_data`=`wdat`. Address increments.
  - Cycles without `wdat_valid` issue nothing; `mem_enb`=0.
  - After the beat where `beats`=0, go to IDLE.
- READ:
  - Every cycle: `mem_enb`=1, `mem_rd`=1, `mem_wr`=0, `mem_r_addr`=addr. Address increments.
  - After the last issue, go to DRAIN.
- DRAIN: no memory access. Last read beat is returned. Go to IDLE.
- Address increment: `addr` = (`addr`+1) mod DEPTH, so DEPTH−1 wraps to 0.
- Beat counter decrements per issued beat. Counter is LEN_W wide and never underflows.
- `rdat` = `mem_r_data`, passed straight through. `rdat_valid` is a register set in any cycle a read was issued.
- `rdat_last` is registered alongside `rdat_valid` and is set for the beat issued with `beats`=0.
- Memory control outputs are combinational from state and inputs. All other outputs are registered.
- `cmd_valid` outside IDLE is ignored; the command is held by the client.
- `wdat_valid` outside WRITE is ignored.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `busy`=0, `wdat_ready`=0, `rdat_valid`=0, `rdat_last`=0. All `mem_*` outputs are 0.
- Reset asserted mid-burst aborts immediately; no further memory access. Any in-flight read beat is dropped (`rdat_valid`=0).
- Command accepted at edge N:
  - First memory issue is in cycle N+1.
  - Read beat k is issued in cycle N+1+k; its `rdat_valid` is high in cycle N+2+k.
- Read burst of L beats occupies L+1 cycles after acceptance (READ L, DRAIN 1). Next `cmd_ready` comes in cycle N+L+2.
- Write burst with no gaps: L cycles, then IDLE at N+L+1.
- Read-issue and write-issue are never simultaneous. `mem_wr` and `mem_rd` are never both 1.

## Structure
- Package `dp_mem_pkg`:
  - `op_e` {OP_READ, OP_WRITE}.
  - `state_e` {IDLE, WRITE, READ, DRAIN}.
  - Default DATA_W/ADDR_W/DEPTH/LEN_W constants, shared with the memory block.
- One sub-module: `dp_mem_burst_cnt`. It holds the address register with modulo-DEPTH wrap and the beat down-counter. It has `load`/`step` inputs and a `last` output.

## Test plan
- Write 1 beat, op=1, addr=3, len=0, wdat=0xA5 → one cycle with `mem_wr`=1, `mem_w_addr`=3, `mem_w_data`=0xA5. Back to IDLE next cycle.
- Write burst, addr=14, len=3, data 0x10..0x13 → writes to addresses 14, 15, 0, 1.
- Read burst, addr=14, len=3, memory preloaded → `mem_r_addr` 14, 15, 0, 1 on consecutive cycles. `rdat_valid` trails issue by 1 cycle. `rdat_last` only on the 4th beat. `cmd_ready` returns 2 cycles after the last issue.
- Write burst len=2 with `wdat_valid` low for 2 cycles between beats → `mem_enb`=0 in gap cycles. Exactly 3 writes to consecutive addresses.
- Assert `rst` during the 2nd beat of a 4-beat read → all outputs 0 asynchronously. No `rdat_valid` afterward. `cmd_ready`=1 after release.
- Back-to-back: write len=1 at 5, then read len=1 at 5 → read returns the written values in order. `mem_wr` & `mem_rd` never both high.
